// File: rtl/ffd_linha_atraso.sv
// Enable-gated delay line: DEPTH stages of WIDTH-bit words with valid bits,
// a run-time selectable tap and a count of valid words in flight.
module ffd_linha_atraso #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             habilita,
  input  logic             limpa,
  input  logic [WIDTH-1:0] dados,
  input  logic             dados_validos,
  input  logic [AW-1:0]    atraso,
  output logic [WIDTH-1:0] saida,
  output logic             saida_valida,
  output logic [AW-1:0]    ocupacao
);

  localparam logic [AW-1:0] DEPTH_AW = AW'(DEPTH);

  logic [WIDTH-1:0] estagio_r [DEPTH];
  logic [DEPTH-1:0] valido_r;
  logic [AW-1:0]    ocupacao_r;
  logic [AW-1:0]    tap_s;
  logic [AW-1:0]    ocupacao_prox_s;

  // Shift register stages, valid bits and occupancy counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        estagio_r[k] <= '0;
      end
      valido_r   <= '0;
      ocupacao_r <= '0;
    end else if (limpa) begin
      for (int k = 0; k < DEPTH; k++) begin
        estagio_r[k] <= '0;
      end
      valido_r   <= '0;
      ocupacao_r <= '0;
    end else if (habilita) begin
      estagio_r[0] <= dados;
      valido_r[0]  <= dados_validos;
      for (int k = 1; k < DEPTH; k++) begin
        estagio_r[k] <= estagio_r[k-1];
        valido_r[k]  <= valido_r[k-1];
      end
      ocupacao_r <= ocupacao_prox_s;
    end else begin
      ocupacao_r <= ocupacao_r;
    end
  end

  // Word entering and word leaving on the same edge cancel out
  always_comb begin
    ocupacao_prox_s = ocupacao_r + AW'(dados_validos) - AW'(valido_r[DEPTH-1]);
  end

  // Clamp the requested delay into 1..DEPTH and convert to a stage index
  always_comb begin
    tap_s = '0;
    if (atraso == {AW{1'b0}}) begin
      tap_s = '0;
    end else if (atraso > DEPTH_AW) begin
      tap_s = DEPTH_AW - AW'(1);
    end else begin
      tap_s = atraso - AW'(1);
    end
  end

  // Tap mux, written as a compare loop so the index width never exceeds the array
  always_comb begin
    saida        = '0;
    saida_valida = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (tap_s == AW'(k)) begin
        saida        = estagio_r[k];
        saida_valida = valido_r[k];
      end else begin
        saida        = saida;
        saida_valida = saida_valida;
      end
    end
  end

  assign ocupacao = ocupacao_r;

endmodule

// File: tb/tb_ffd_linha_atraso.sv
// Randomised and directed bench for ffd_linha_atraso against a queue model.
module tb_ffd_linha_atraso;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH + 1);

  logic             clk_tb = 1'b0;
  logic             rst;
  logic             habilita;
  logic             limpa;
  logic [WIDTH-1:0] dados;
  logic             dados_validos;
  logic [AW-1:0]    atraso;
  logic [WIDTH-1:0] saida;
  logic             saida_valida;
  logic [AW-1:0]    ocupacao;

  int n_chk  = 0;
  int n_pass = 0;

  ffd_linha_atraso #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk_tb), .rst(rst), .habilita(habilita), .limpa(limpa),
    .dados(dados), .dados_validos(dados_validos), .atraso(atraso),
    .saida(saida), .saida_valida(saida_valida), .ocupacao(ocupacao)
  );

  always #5 clk_tb = ~clk_tb;

  // Model: history of the last DEPTH shifted-in {valid,data}, newest at index 0
  logic [WIDTH:0] mq[$];

  task automatic model_clear();
    mq.delete();
    for (int i = 0; i < DEPTH; i++) mq.push_back('0);
  endtask

  initial model_clear();

  always @(posedge clk_tb or negedge rst) begin
    if (!rst) model_clear();
    else if (limpa) model_clear();
    else if (habilita) begin
      mq.push_front({dados_validos, dados});
      void'(mq.pop_back());
    end
  end

  function automatic int eff_delay(input logic [AW-1:0] a);
    if (a == 0) return 1;
    if (int'(a) > DEPTH) return DEPTH;
    return int'(a);
  endfunction

  function automatic int model_occ();
    int c = 0;
    foreach (mq[i]) c += int'(mq[i][WIDTH]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk_tb) begin
    logic [WIDTH:0] e;
    e = mq[eff_delay(atraso) - 1];
    chk("model_saida", 32'(saida), 32'(e[WIDTH-1:0]));
    chk("model_valida", 32'(saida_valida), 32'(e[WIDTH]));
    chk("model_ocupacao", 32'(ocupacao), 32'(model_occ()));
  end

  task automatic cyc(input logic h, input logic l, input logic [WIDTH-1:0] d, input logic v);
    habilita = h; limpa = l; dados = d; dados_validos = v;
    @(posedge clk_tb);
    #1;
  endtask

  task automatic expect3(input string name, input logic [WIDTH-1:0] s, input logic sv, input int oc);
    chk({name, "_saida"}, 32'(saida), 32'(s));
    chk({name, "_valida"}, 32'(saida_valida), 32'(sv));
    chk({name, "_ocup"}, 32'(ocupacao), 32'(oc));
  endtask

  initial begin
    rst = 1'b0; habilita = 1'b0; limpa = 1'b0; dados = '0; dados_validos = 1'b0;
    atraso = AW'(2);
    repeat (2) @(posedge clk_tb);
    #1;
    expect3("reset", 8'h00, 1'b0, 0);
    rst = 1'b1;

    // Basic latency with atraso=2
    cyc(1'b1, 1'b0, 8'h11, 1'b1); chk("seq_ocup1", 32'(ocupacao), 32'd1);
    cyc(1'b1, 1'b0, 8'h22, 1'b1); expect3("seq2", 8'h11, 1'b1, 2);
    cyc(1'b1, 1'b0, 8'h33, 1'b1); expect3("seq3", 8'h22, 1'b1, 3);

    // Stall after 0x22 enters
    cyc(1'b1, 1'b1, 8'h00, 1'b0); expect3("clr", 8'h00, 1'b0, 0);
    cyc(1'b1, 1'b0, 8'h11, 1'b1);
    cyc(1'b1, 1'b0, 8'h22, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 8'hEE, 1'b1); expect3("stall", 8'h11, 1'b1, 2);
    end
    cyc(1'b1, 1'b0, 8'h33, 1'b1); expect3("resume1", 8'h22, 1'b1, 3);
    cyc(1'b1, 1'b0, 8'h00, 1'b0); expect3("resume2", 8'h33, 1'b1, 3);

    // Tap clamping takes effect combinationally
    atraso = AW'(0); #1; chk("tap0_valida", 32'(saida_valida), 32'd0);
    atraso = AW'(7); #1; expect3("tap7", 8'h11, 1'b1, 3);
    atraso = AW'(4); #1; chk("tap4_saida", 32'(saida), 32'h11);

    // atraso=7: word at edge N appears after edge N+3
    atraso = AW'(7);
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h77, 1'b1);
    cyc(1'b1, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0); chk("lat4_early", 32'(saida_valida), 32'd0);
    cyc(1'b1, 1'b0, 8'h00, 1'b0); expect3("lat4", 8'h77, 1'b1, 1);

    // Saturation then drain
    atraso = AW'(4);
    cyc(1'b1, 1'b1, 8'h00, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      cyc(1'b1, 1'b0, 8'(i), 1'b1);
      chk("sat_ocup", 32'(ocupacao), 32'((i > 4) ? 4 : i));
    end
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b1, 1'b0, 8'h00, 1'b0);
      chk("drain_ocup", 32'(ocupacao), 32'(4 - i));
    end
    chk("drain_valida", 32'(saida_valida), 32'd0);

    // Clear with a full pipeline wins over a valid input
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
    chk("full_ocup", 32'(ocupacao), 32'd4);
    atraso = AW'(1);
    cyc(1'b1, 1'b1, 8'hAA, 1'b1); expect3("clr_full", 8'h00, 1'b0, 0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 8'(8'h50 + i), 1'b1);
    expect3("pre_rst", 8'h52, 1'b1, 3);
    #2 rst = 1'b0;
    #1 expect3("async_rst", 8'h00, 1'b0, 0);
    @(posedge clk_tb); #1;
    rst = 1'b1;
    cyc(1'b1, 1'b0, 8'h5A, 1'b1); expect3("post_rst", 8'h5A, 1'b1, 1);

    // Random stream; the negedge compare does the checking
    for (int i = 0; i < 400; i++) begin
      atraso = AW'($urandom_range(0, 7));
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
          8'($urandom), 1'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
